// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_pkg: shared constants, frame FSM state type and parity helper for the
// PS/2 keyboard receiver (ps2_keyboard_rx, ps2_frame_rx).
// No ports.
package ps2_pkg;

    localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS   = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } frame_state_e;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
        return ^data_and_parity;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: groups the PS/2 pin inputs and the decoded key-event
// outputs of ps2_keyboard_rx.
//   ps2_clk, ps2_data          raw PS/2 pins (driven by master)
//   keycode[7:0], make,        last decoded event (driven by slave)
//   extended, keycode_ready,
//   frame_err
// Modports: master = keyboard/datapath side, slave = receiver.
interface ps2_keyboard_rx_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       make;
    logic       extended;
    logic       keycode_ready;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  keycode, make, extended, keycode_ready, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keycode, make, extended, keycode_ready, frame_err
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the raw PS/2 pins, glitch-filters ps2_clk and
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   ps2_clk_i          raw PS/2 clock pin (asynchronous)
//   ps2_data_i         raw PS/2 data pin (asynchronous)
//   byte_o[7:0]        received data byte, valid with byte_valid_o
//   byte_valid_o       one-cycle strobe: frame passed parity and stop checks
//   byte_err_o         one-cycle strobe: parity/stop error or watchdog timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_err_o
);

    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 2);

    logic          clk_meta_q, clk_sync_q;
    logic          data_meta_q, data_sync_q;
    logic          clk_filt_q, clk_filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall_w;

    frame_state_e  state_q;
    logic [3:0]    bitcnt_q;
    logic [9:0]    shift_q;
    logic [WW-1:0] wd_q;
    logic          timeout_q;
    logic          frame_ok_w;

    // Input synchronisers and clock glitch filter. Lines idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q      <= 1'b1;
            clk_sync_q      <= 1'b1;
            data_meta_q     <= 1'b1;
            data_sync_q     <= 1'b1;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
            filt_cnt_q      <= '0;
        end else begin
            clk_meta_q      <= ps2_clk_i;
            clk_sync_q      <= clk_meta_q;
            data_meta_q     <= ps2_data_i;
            data_sync_q     <= data_meta_q;
            clk_filt_prev_q <= clk_filt_q;
            // Count consecutive samples that disagree with the filtered level;
            // any agreeing sample restarts the count.
            if (clk_sync_q == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                clk_filt_q <= clk_sync_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall_w = clk_filt_prev_q & ~clk_filt_q;

    // Frame FSM with watchdog. Bits enter at the MSB so that after ten shifts
    // shift_q = {stop, parity, data[7:0]}.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (fall_w && !data_sync_q) begin
                        state_q  <= ST_SHIFT;
                        bitcnt_q <= '0;
                        wd_q     <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (fall_w) begin
                        wd_q     <= '0;
                        shift_q  <= {data_sync_q, shift_q[9:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST_BIT) begin
                            state_q <= ST_CHECK;
                        end
                    end else if (wd_q == WD_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode the registered CHECK state so the top can register the
    // event one cycle later (two cycles after the stop-bit edge).
    assign frame_ok_w   = odd_parity_ok(shift_q[8:0]) & shift_q[9];
    assign byte_o       = shift_q[7:0];
    assign byte_valid_o = (state_q == ST_CHECK) & frame_ok_w;
    assign byte_err_o   = ((state_q == ST_CHECK) & ~frame_ok_w) | timeout_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver. Strips F0 (break) and E0
// (extended) prefixes and emits one key event per scan sequence.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   bus (slave)   ps2_clk/ps2_data pins in; keycode, make, extended,
//                 keycode_ready (event strobe), frame_err (error strobe) out
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses auto-repeat makes
// of the key currently held.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic              clk,
    input  logic              reset,
    ps2_keyboard_rx_if.slave  bus
);

    logic [7:0] byte_w;
    logic       byte_valid_w;
    logic       byte_err_w;
    logic       is_prefix_w;
    logic       suppress_w;

    logic [7:0] keycode_q;
    logic       make_q;
    logic       extended_q;
    logic       keycode_ready_q;
    logic       frame_err_q;
    logic       brk_q;
    logic       ext_q;

    ps2_frame_rx #(
        .FILTER_CYCLES  (FILTER_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .byte_o       (byte_w),
        .byte_valid_o (byte_valid_w),
        .byte_err_o   (byte_err_w)
    );

    assign is_prefix_w = (byte_w == PS2_BREAK_PREFIX) || (byte_w == PS2_EXT_PREFIX);

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] held_q;
    logic       held_vld_q;

    assign suppress_w = ~brk_q & held_vld_q & (held_q == {ext_q, byte_w});

    always_ff @(posedge clk) begin
        if (reset) begin
            held_q     <= '0;
            held_vld_q <= 1'b0;
        end else if (byte_valid_w && !is_prefix_w) begin
            if (!brk_q) begin
                held_q     <= {ext_q, byte_w};
                held_vld_q <= 1'b1;
            end else if (held_vld_q && (held_q == {ext_q, byte_w})) begin
                held_vld_q <= 1'b0;
            end
        end
    end
`else
    assign suppress_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            keycode_q       <= '0;
            make_q          <= 1'b0;
            extended_q      <= 1'b0;
            keycode_ready_q <= 1'b0;
            frame_err_q     <= 1'b0;
            brk_q           <= 1'b0;
            ext_q           <= 1'b0;
        end else begin
            keycode_ready_q <= 1'b0;
            frame_err_q     <= 1'b0;
            if (byte_err_w) begin
                frame_err_q <= 1'b1;
                brk_q       <= 1'b0;
                ext_q       <= 1'b0;
            end else if (byte_valid_w) begin
                if (byte_w == PS2_BREAK_PREFIX) begin
                    brk_q <= 1'b1;
                end else if (byte_w == PS2_EXT_PREFIX) begin
                    ext_q <= 1'b1;
                end else begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                    if (!suppress_w) begin
                        keycode_q       <= byte_w;
                        make_q          <= ~brk_q;
                        extended_q      <= ext_q;
                        keycode_ready_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.keycode       = keycode_q;
    assign bus.make          = make_q;
    assign bus.extended      = extended_q;
    assign bus.keycode_ready = keycode_ready_q;
    assign bus.frame_err     = frame_err_q;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver that produces the keycode stream the game datapath consumes.
- Samples the keyboard's open-collector ps2_clk/ps2_data lines and deserialises 11-bit frames.
- Strips the F0 (break) and E0 (extended) prefixes and emits one decoded key event per scan sequence as keycode/make/keycode_ready.
- Sits between the board PS/2 pins and the datapath/controller.

Parameters:
- FILTER_CYCLES, 8: consecutive identical synchronised samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 100_000: clk cycles (2 ms at 50 MHz) with no filtered falling edge before an in-progress frame is aborted.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
- ps2_data  in  1  raw PS/2 data pin (asynchronous)
- keycode  out  8  scan code of last event, prefixes removed
- make  out  1  1 = key pressed, 0 = key released
- extended  out  1  1 = event was E0-prefixed
- keycode_ready  out  1  one-cycle strobe: new event valid on keycode/make/extended
- frame_err  out  1  one-cycle strobe on parity, stop or timeout error

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on port reset.
  - Reset values: keycode=8'h00, make=0, extended=0, keycode_ready=0, frame_err=0.
  - Reset also clears the bit counter, shift register, prefix flags and filter state.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk then goes through a glitch filter: the filtered level changes only after FILTER_CYCLES equal consecutive samples.
  - Falling edge = filtered level 1->0. ps2_data is sampled on the cycle the edge is detected.
- Frame FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on an edge with data=0 (start bit), go to SHIFT, bitcnt=0. Start bit = 1: ignore, stay in IDLE.
  - SHIFT: on each edge, shift data in, LSB first. Bits 0-7 are data, bit 8 is parity, bit 9 is stop. After the stop bit, go to CHECK.
  - CHECK (one cycle): valid if odd parity over data+parity is correct and stop=1. Valid frame: byte passed to the prefix logic. Invalid: frame_err pulses the following cycle and the prefix flags clear. Returns to IDLE either way.
  - Watchdog: in SHIFT, a counter resets on every edge. Reaching TIMEOUT_CYCLES → frame_err pulse, return to IDLE, prefix flags clear.
- Prefix decode, on a valid byte:
  - F0: set brk. No output.
  - E0: set ext. No output.
  - Any other byte B: on the next cycle keycode=B, make=~brk, extended=ext, keycode_ready=1 for exactly one cycle. Then clear brk and ext.
  - Both orders are accepted: E0 F0 B and F0 E0 B each give extended break.
  - E1 and AA carry no special meaning; they are reported as ordinary codes.
- Output hold: keycode/make/extended hold their values until the next event.
- Latency: keycode_ready rises 2 clk cycles after the filtered falling edge of the stop bit.
- Simultaneous events: frame_err and keycode_ready are never asserted in the same cycle.
- Reset mid-frame or mid-prefix: the partial frame and any pending F0/E0 are discarded.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A register holds {extended, keycode} of the key currently held.
  - A make event matching the held key is suppressed: no keycode_ready, outputs unchanged.
  - A make for a different key is reported and replaces the held key.
  - A break matching the held key clears the register and is reported. Breaks are always reported.
  - Reset clears the register.
- Undefined: every make, including auto-repeat, is reported.

Decomposition:
- Package ps2_pkg:
  - PS2_BREAK_PREFIX = 8'hF0, PS2_EXT_PREFIX = 8'hE0, PS2_FRAME_BITS = 11.
  - Frame FSM state enum.
- Sub-module ps2_frame_rx:
  - Contains the synchronisers, glitch filter, frame FSM and watchdog.
  - Outputs byte[7:0], byte_valid and byte_err strobes.
- Top level: prefix decode, output registers and the optional typematic filter.

Test Plan:
- Frame 8'h1C, parity 0, stop 1 → single keycode_ready pulse; keycode=8'h1C, make=1, extended=0; frame_err never asserted.
- Frames F0, 1C → no pulse after F0; one pulse after 1C with keycode=8'h1C, make=0, extended=0.
- Frames E0,75 then E0,F0,75 → first pulse keycode=8'h75, make=1, extended=1; second pulse keycode=8'h75, make=0, extended=1.
- Frame 8'h1C with parity bit inverted → frame_err pulses once, no keycode_ready. Then a valid 8'h1C → normal make event.
- 5 bits of a frame, then ps2_clk idle for 100_000 cycles → frame_err pulse. Send F0, assert reset for 1 cycle, send 1C → make=1 (pending break discarded).
- Frames 1C,1C,1C,F0,1C → with PS2_TYPEMATIC_FILTER_EN: 2 pulses (make, break); without: 4 pulses (3 make, 1 break). Also: 2-cycle glitch on ps2_clk → no bit shifted.
